// File: rtl/some_vip_initiator.sv
// some_vip_initiator
//   Initiator side of the some_vip valid/ready byte channel. Bytes pushed by
//   local logic are queued in a small first-word-fall-through FIFO and
//   presented to a responder as a valid/ready stream. On every handshake the
//   responder's return byte is captured and reported on the response port,
//   and a wrapping transfer counter is incremented.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   push_i          enqueue push_data_i this cycle (dropped while full_o=1)
//   push_data_i     byte to enqueue
//   full_o          FIFO holds DEPTH entries
//   count_o         current FIFO occupancy
//   overflow_o      sticky: a push arrived while full_o=1
//   valid_o/data_o  channel request towards the responder (data_o=0 when idle)
//   ready_i/data_i  responder handshake and return byte
//   rsp_valid_o     one-cycle pulse after each completed transfer
//   rsp_data_o      return byte captured at the last handshake
//   xfer_cnt_o      completed transfers, wraps modulo 2^CNT_W
module some_vip_initiator #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       ready_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [CNT_W-1:0]           xfer_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] XFER_ONE = CNT_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

  logic full;
  logic valid;
  logic hs;
  logic push_ok;

  always_comb begin
    // Status is decoded from registered state only, so a pop in the same
    // cycle never frees room for a push that arrived while full.
    full    = (count_q == CNT_FULL);
    valid   = (count_q != '0);
    hs      = valid & ready_i;
    push_ok = push_i & ~full;

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (push_i & full);
    rsp_valid_d = hs;
    rsp_data_d  = rsp_data_q;
    xfer_cnt_d  = xfer_cnt_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      // DEPTH is a power of two, so the pointer wraps on its own.
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (hs) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rsp_data_d = data_i;
      xfer_cnt_d = xfer_cnt_q + XFER_ONE;
    end

    case ({push_ok, hs})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Register stage: control state is reset, FIFO storage is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head entry falls through to the channel; idle channel drives zero.
  assign valid_o     = valid;
  assign data_o      = valid ? mem_q[rd_ptr_q] : '0;
  assign full_o      = full;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_some_vip_initiator.sv
module tb_some_vip_initiator;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              full_o;
  logic [CW-1:0]     count_o;
  logic              overflow_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [CNT_W-1:0]  xfer_cnt_o;

  int errors = 0;
  int checks = 0;

  some_vip_initiator #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .data_i      (data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .xfer_cnt_o  (xfer_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs held across one rising edge, outputs expected just after it.
  typedef struct {
    logic        rst;
    logic        push;
    logic [7:0]  pdata;
    logic        ready;
    logic [7:0]  din;
    logic        valid;
    logic [7:0]  data;
    logic        full;
    int          count;
    logic        ovf;
    logic        rsp_v;
    logic [7:0]  rsp_d;
    int          xfer;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic p, logic [7:0] pd, logic rd, logic [7:0] di,
                              logic v, logic [7:0] d, logic f, int c, logic o,
                              logic rv, logic [7:0] rdat, int x);
    vec_t t;
    t.rst = r; t.push = p; t.pdata = pd; t.ready = rd; t.din = di;
    t.valid = v; t.data = d; t.full = f; t.count = c; t.ovf = o;
    t.rsp_v = rv; t.rsp_d = rdat; t.xfer = x;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int row, input vec_t t);
    chk("valid_o",     row, 32'(valid_o),     32'(t.valid));
    chk("data_o",      row, 32'(data_o),      32'(t.data));
    chk("full_o",      row, 32'(full_o),      32'(t.full));
    chk("count_o",     row, 32'(count_o),     32'(t.count));
    chk("overflow_o",  row, 32'(overflow_o),  32'(t.ovf));
    chk("rsp_valid_o", row, 32'(rsp_valid_o), 32'(t.rsp_v));
    chk("rsp_data_o",  row, 32'(rsp_data_o),  32'(t.rsp_d));
    chk("xfer_cnt_o",  row, 32'(xfer_cnt_o),  32'(t.xfer));
  endtask

  initial begin
    rst = 1'b1; push_i = 1'b0; push_data_i = '0; ready_i = 1'b0; data_i = '0;

    //             rst push pd    rdy din    valid data  full cnt ovf rspv rspd  xfer
    // Reset held with push and ready asserted, then first cycle out of reset.
    tbl.push_back(mk(1, 1, 8'h99, 1, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h98, 1, 8'h12, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h13, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    // Single transfer with three stalled cycles.
    tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'hEE, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'hEE, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'hEE, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h3C, 1));
    // Fill to full, fifth push overflows and is dropped, then drain.
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h02, 0, 8'h00, 1, 8'h01, 0, 2, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 1, 8'h01, 0, 3, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h04, 0, 8'h00, 1, 8'h01, 1, 4, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h05, 0, 8'h00, 1, 8'h01, 1, 4, 1, 0, 8'h3C, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h81, 1, 8'h02, 0, 3, 1, 1, 8'h81, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h82, 1, 8'h03, 0, 2, 1, 1, 8'h82, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h83, 1, 8'h04, 0, 1, 1, 1, 8'h83, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h84, 0, 8'h00, 0, 0, 1, 1, 8'h84, 5));
    // Streaming 0x10..0x19 with ready held high; pointers wrap several times.
    tbl.push_back(mk(0, 1, 8'h10, 1, 8'h40, 1, 8'h10, 0, 1, 1, 0, 8'h84, 5));
    for (int k = 1; k < 10; k++)
      tbl.push_back(mk(0, 1, 8'(8'h10 + k), 1, 8'(8'h40 + k),
                       1, 8'(8'h10 + k), 0, 1, 1, 1, 8'(8'h40 + k), 5 + k));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h4A, 0, 8'h00, 0, 0, 1, 1, 8'h4A, 15));
    // Reset, fill, then push while full with a simultaneous pop.
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h21, 0, 8'h00, 1, 8'h21, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h22, 0, 8'h00, 1, 8'h21, 0, 2, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 1, 8'h21, 0, 3, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h24, 0, 8'h00, 1, 8'h21, 1, 4, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h25, 1, 8'h55, 1, 8'h22, 0, 3, 1, 1, 8'h55, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h56, 1, 8'h23, 0, 2, 1, 1, 8'h56, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h57, 1, 8'h24, 0, 1, 1, 1, 8'h57, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h58, 0, 8'h00, 0, 0, 1, 1, 8'h58, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h59, 0, 8'h00, 0, 0, 1, 0, 8'h58, 4));
    // Reset mid-operation: three entries queued, reset discards them.
    tbl.push_back(mk(0, 1, 8'h31, 0, 8'h00, 1, 8'h31, 0, 1, 1, 0, 8'h58, 4));
    tbl.push_back(mk(0, 1, 8'h32, 0, 8'h00, 1, 8'h31, 0, 2, 1, 0, 8'h58, 4));
    tbl.push_back(mk(0, 1, 8'h33, 0, 8'h00, 1, 8'h31, 0, 3, 1, 0, 8'h58, 4));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));

    step();
    foreach (tbl[i]) begin
      rst = tbl[i].rst; push_i = tbl[i].push; push_data_i = tbl[i].pdata;
      ready_i = tbl[i].ready; data_i = tbl[i].din;
      step();
      check_all(i, tbl[i]);
    end

    // Hand-written: ready_i/data_i toggling mid-cycle must not reach any output.
    rst = 1'b0; push_i = 1'b1; push_data_i = 8'h6B; ready_i = 1'b0; data_i = 8'h00;
    step();
    push_i = 1'b0;
    chk("seq_valid_after_push", 100, 32'(valid_o), 32'd1);
    ready_i = 1'b1; data_i = 8'hC7;
    #2;
    chk("seq_comb_rsp_valid", 101, 32'(rsp_valid_o), 32'd0);
    chk("seq_comb_rsp_data",  102, 32'(rsp_data_o),  32'd0);
    chk("seq_comb_count",     103, 32'(count_o),     32'd1);
    chk("seq_comb_data",      104, 32'(data_o),      32'h6B);
    step();
    ready_i = 1'b0;
    chk("seq_rsp_pulse", 105, 32'(rsp_valid_o), 32'd1);
    chk("seq_rsp_data",  106, 32'(rsp_data_o),  32'hC7);
    chk("seq_xfer",      107, 32'(xfer_cnt_o),  32'd1);
    step();
    chk("seq_rsp_single", 108, 32'(rsp_valid_o), 32'd0);
    chk("seq_rsp_hold",   109, 32'(rsp_data_o),  32'hC7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
